// File: rtl/avalon_st_pkg.sv
// Shared Avalon-ST definitions: arbitration FSM state encoding.
package avalon_st_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible requester after 'last', wrapping.
module rr_pick #(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned GW         = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [GW-1:0]         last,
  input  logic [NUM_INPUTS-1:0] mask,
  output logic                  any,
  output logic [GW-1:0]         idx
);

  logic [NUM_INPUTS-1:0] elig;
  int unsigned           pos;
  logic [GW-1:0]         sel;

  assign elig = req & ~mask;

  // Offsets 1..NUM_INPUTS visit last+1 first and 'last' itself at the end.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    sel = '0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      pos = (32'(last) + k) % NUM_INPUTS;
      sel = GW'(pos);
      if (!any && elig[sel]) begin
        any = 1'b1;
        idx = sel;
      end
    end
  end

endmodule

// File: rtl/avalon_st_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one Avalon-ST output among
// NUM_INPUTS requesters, with zero-bubble handover at eop.
module avalon_st_pkt_arbiter
  import avalon_st_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_INPUTS = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_INPUTS-1:0]                   in_vld,
  output logic [NUM_INPUTS-1:0]                   in_rdy,
  input  logic [NUM_INPUTS-1:0]                   in_sop,
  input  logic [NUM_INPUTS-1:0]                   in_eop,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]        in_data,
  input  logic [NUM_INPUTS*$clog2(DATA_WIDTH)-1:0] in_empty,
  output logic                                    out_vld,
  output logic                                    out_sop,
  output logic                                    out_eop,
  input  logic                                    out_rdy,
  output logic [DATA_WIDTH-1:0]                   out_data,
  output logic [$clog2(DATA_WIDTH)-1:0]           out_empty,
  output logic [$clog2(NUM_INPUTS)-1:0]           grant,
  output logic                                    busy,
  output logic                                    err_sop
);

  localparam int unsigned EW = $clog2(DATA_WIDTH);
  localparam int unsigned GW = $clog2(NUM_INPUTS);

  arb_state_t            state;
  logic [GW-1:0]         last_q;
  logic                  first_beat;
  logic                  xfer;
  logic                  pick_any;
  logic [GW-1:0]         pick_idx;
  logic [NUM_INPUTS-1:0] pick_mask;

  assign busy = (state == BUSY);

  // While busy the picker only runs for the eop handover, where the owner is excluded.
  assign pick_mask = busy ? (NUM_INPUTS'(1) << grant) : '0;

  rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .GW         (GW)
  ) u_pick (
    .req  (in_vld),
    .last (last_q),
    .mask (pick_mask),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    out_vld   = busy & in_vld[grant];
    out_sop   = in_sop[grant];
    out_eop   = in_eop[grant];
    out_data  = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
    out_empty = in_empty[grant*EW +: EW];
    in_rdy    = '0;
    if (busy) begin
      in_rdy[grant] = out_rdy;
    end
  end

  assign xfer    = out_vld & out_rdy;
  assign err_sop = xfer & first_beat & ~out_sop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_q     <= GW'(NUM_INPUTS - 1);
      first_beat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= BUSY;
            grant      <= pick_idx;
            last_q     <= pick_idx;
            first_beat <= 1'b1;
          end
        end
        BUSY: begin
          if (xfer) begin
            first_beat <= 1'b0;
            if (out_eop) begin
              if (pick_any) begin
                grant      <= pick_idx;
                last_q     <= pick_idx;
                first_beat <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_st_pkt_arbiter.sv
// Self-checking bench for avalon_st_pkt_arbiter: directed scenarios plus a
// randomized run against a packet-level round-robin reference model.
module tb_avalon_st_pkt_arbiter;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int EW = $clog2(DW);
  localparam int GW = $clog2(NI);

  logic             clk = 1'b0;
  logic             rst;
  logic [NI-1:0]    in_vld, in_rdy, in_sop, in_eop;
  logic [NI*DW-1:0] in_data;
  logic [NI*EW-1:0] in_empty;
  logic             out_vld, out_sop, out_eop, out_rdy;
  logic [DW-1:0]    out_data;
  logic [EW-1:0]    out_empty;
  logic [GW-1:0]    grant;
  logic             busy, err_sop;

  always #5 clk = ~clk;

  avalon_st_pkt_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .out_vld   (out_vld),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_empty (out_empty),
    .grant     (grant),
    .busy      (busy),
    .err_sop   (err_sop)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          err;
    int            cyc;
  } xfer_t;

  typedef struct {
    logic          vld, sop, eop, busy, err;
    logic [DW-1:0] data;
    logic [EW-1:0] empty;
    logic [GW-1:0] grant;
    logic [NI-1:0] in_rdy, ivld, isop, ieop;
    logic [NI*DW-1:0] idata;
    logic [NI*EW-1:0] iempty;
    int            src;
  } obs_t;

  beat_t src_q[NI][$];
  bit    vld_en[NI];
  xfer_t xlog[$];
  int    cyc;
  int    checks;
  int    errors;

  function automatic logic [DW-1:0] mk_data(int s, int p, int b);
    return {8'(s), 8'(p), 16'(b)};
  endfunction

  task automatic push_beat(int s, logic [DW-1:0] d, logic sop, logic eop);
    beat_t b;
    b.data  = d;
    b.sop   = sop;
    b.eop   = eop;
    b.empty = EW'($urandom);
    src_q[s].push_back(b);
  endtask

  task automatic push_pkt(int s, int p, int len, bit with_sop);
    for (int k = 0; k < len; k++)
      push_beat(s, mk_data(s, p, k), (k == 0) && with_sop, k == len - 1);
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NI; i++) begin
      src_q[i].delete();
      vld_en[i] = 1'b1;
    end
  endtask

  // Called at a falling edge: drive inputs, sample late in the low phase,
  // let the sources consume on the rising edge, return at the next falling edge.
  task automatic step(output obs_t o);
    beat_t b;
    for (int i = 0; i < NI; i++) begin
      if (vld_en[i] && src_q[i].size() > 0) begin
        b = src_q[i][0];
        in_vld[i] = 1'b1;
        in_sop[i] = b.sop;
        in_eop[i] = b.eop;
        in_data[i*DW +: DW]  = b.data;
        in_empty[i*EW +: EW] = b.empty;
      end else begin
        in_vld[i] = 1'b0;
        in_sop[i] = 1'($urandom);
        in_eop[i] = 1'($urandom);
        in_data[i*DW +: DW]  = DW'($urandom);
        in_empty[i*EW +: EW] = EW'($urandom);
      end
    end
    #3;
    o.vld = out_vld; o.sop = out_sop; o.eop = out_eop; o.busy = busy;
    o.err = err_sop; o.data = out_data; o.empty = out_empty; o.grant = grant;
    o.in_rdy = in_rdy; o.ivld = in_vld; o.isop = in_sop; o.ieop = in_eop;
    o.idata = in_data; o.iempty = in_empty; o.src = -1;
    for (int i = 0; i < NI; i++)
      if (in_vld[i] && in_rdy[i]) o.src = i;
    if (out_vld && out_rdy)
      xlog.push_back('{src: o.src, data: out_data, sop: out_sop, eop: out_eop,
                       err: err_sop, cyc: cyc});
    @(posedge clk);
    if (o.src >= 0) void'(src_q[o.src].pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    obs_t o;
    clear_sources();
    out_rdy = 1'b1;
    rst = 1'b1;
    step(o);
    step(o);
    rst = 1'b0;
    xlog.delete();
  endtask

  function automatic int rr_next(logic [NI-1:0] v, int last, int excl);
    for (int s = 1; s <= NI; s++)
      if (((last + s) % NI) != excl && v[(last + s) % NI]) return (last + s) % NI;
    return -1;
  endfunction

  task automatic test_reset();
    obs_t o;
    do_reset();
    step(o);
    checks++;
    if (o.busy !== 1'b0 || o.vld !== 1'b0 || o.in_rdy !== '0 || o.err !== 1'b0 || o.grant !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b vld=%b in_rdy=%b err=%b grant=%0d exp 0 0 0000 0 0",
               o.busy, o.vld, o.in_rdy, o.err, o.grant);
    end
    checks++;
    if (o.data !== o.idata[DW-1:0]) begin
      errors++;
      $display("FAIL reset_mux got %h exp %h", o.data, o.idata[DW-1:0]);
    end
  endtask

  task automatic test_single();
    obs_t o;
    do_reset();
    push_pkt(2, 0, 3, 1'b1);
    step(o);
    checks++;
    if (o.busy !== 1'b0 || o.vld !== 1'b0) begin
      errors++;
      $display("FAIL single_bubble got busy=%b vld=%b exp 0 0", o.busy, o.vld);
    end
    for (int b = 0; b < 3; b++) begin
      step(o);
      checks++;
      if ({o.busy, o.vld, o.sop, o.eop} !== {2'b11, 1'(b == 0), 1'(b == 2)} ||
          o.grant !== GW'(2) || o.data !== mk_data(2, 0, b)) begin
        errors++;
        $display("FAIL single_beat%0d got busy=%b vld=%b sop=%b eop=%b grant=%0d data=%h exp 1 1 %b %b 2 %h",
                 b, o.busy, o.vld, o.sop, o.eop, o.grant, o.data, b == 0, b == 2, mk_data(2, 0, b));
      end
    end
    step(o);
    checks++;
    if (o.busy !== 1'b0 || o.vld !== 1'b0 || o.grant !== GW'(2)) begin
      errors++;
      $display("FAIL single_release got busy=%b vld=%b grant=%0d exp 0 0 2", o.busy, o.vld, o.grant);
    end
  endtask

  task automatic test_three_way();
    obs_t o;
    int exp_src[6] = '{0, 0, 1, 1, 3, 3};
    do_reset();
    push_pkt(0, 1, 2, 1'b1);
    push_pkt(1, 1, 2, 1'b1);
    push_pkt(3, 1, 2, 1'b1);
    for (int k = 0; k < 12; k++) step(o);
    checks++;
    if (xlog.size() != 6) begin
      errors++;
      $display("FAIL three_count got %0d exp 6", xlog.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (xlog[k].src != exp_src[k] || xlog[k].data !== mk_data(exp_src[k], 1, k % 2) ||
            xlog[k].cyc != xlog[0].cyc + k) begin
          errors++;
          $display("FAIL three_beat%0d got src=%0d data=%h cyc=%0d exp src=%0d data=%h cyc=%0d",
                   k, xlog[k].src, xlog[k].data, xlog[k].cyc, exp_src[k],
                   mk_data(exp_src[k], 1, k % 2), xlog[0].cyc + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int sops[$];
    int exp_src[4] = '{1, 3, 1, 3};
    do_reset();
    push_pkt(1, 2, 2, 1'b1);
    push_pkt(1, 3, 2, 1'b1);
    push_pkt(3, 2, 2, 1'b1);
    push_pkt(3, 3, 2, 1'b1);
    for (int k = 0; k < 12; k++) step(o);
    foreach (xlog[k]) if (xlog[k].sop) sops.push_back(xlog[k].src);
    checks++;
    if (sops.size() != 4 || xlog.size() != 8) begin
      errors++;
      $display("FAIL b2b_count got pkts=%0d beats=%0d exp 4 8", sops.size(), xlog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sops[k] != exp_src[k]) begin
          errors++;
          $display("FAIL b2b_order%0d got %0d exp %0d", k, sops[k], exp_src[k]);
        end
      end
      checks++;
      if (xlog[7].cyc - xlog[0].cyc != 7) begin
        errors++;
        $display("FAIL b2b_gapless got span=%0d exp 7", xlog[7].cyc - xlog[0].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    do_reset();
    push_pkt(0, 4, 4, 1'b1);
    out_rdy = 1'b0;
    step(o);
    for (int k = 1; k < 12; k++) begin
      out_rdy = 1'(k % 2);
      step(o);
      if (o.busy) begin
        checks++;
        if (o.in_rdy !== NI'(out_rdy)) begin
          errors++;
          $display("FAIL bp_in_rdy cycle %0d got %b exp %b", k, o.in_rdy, NI'(out_rdy));
        end
      end
    end
    out_rdy = 1'b1;
    checks++;
    if (xlog.size() != 4) begin
      errors++;
      $display("FAIL bp_count got %0d exp 4", xlog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (xlog[k].data !== mk_data(0, 4, k)) begin
          errors++;
          $display("FAIL bp_beat%0d got %h exp %h", k, xlog[k].data, mk_data(0, 4, k));
        end
      end
    end
  endtask

  task automatic test_err_sop();
    obs_t o;
    int err_cycles = 0;
    do_reset();
    push_beat(2, mk_data(2, 5, 0), 1'b0, 1'b0);
    push_beat(2, mk_data(2, 5, 1), 1'b1, 1'b0);
    push_beat(2, mk_data(2, 5, 2), 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(o);
      if (o.err === 1'b1) err_cycles++;
    end
    checks++;
    if (xlog.size() != 3 || err_cycles != 1) begin
      errors++;
      $display("FAIL err_count got beats=%0d err_cycles=%0d exp 3 1", xlog.size(), err_cycles);
    end else begin
      checks++;
      if (xlog[0].err !== 1'b1 || xlog[1].err !== 1'b0 || xlog[0].data !== mk_data(2, 5, 0)) begin
        errors++;
        $display("FAIL err_flag got err0=%b err1=%b data0=%h exp 1 0 %h",
                 xlog[0].err, xlog[1].err, xlog[0].data, mk_data(2, 5, 0));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    do_reset();
    push_pkt(0, 6, 5, 1'b1);
    step(o);
    step(o);
    step(o);
    rst = 1'b1;
    step(o);
    rst = 1'b0;
    clear_sources();
    step(o);
    checks++;
    if (o.vld !== 1'b0 || o.busy !== 1'b0 || o.in_rdy !== '0) begin
      errors++;
      $display("FAIL rst_mid got vld=%b busy=%b in_rdy=%b exp 0 0 0000", o.vld, o.busy, o.in_rdy);
    end
    push_pkt(0, 7, 1, 1'b1);
    push_pkt(2, 7, 1, 1'b1);
    step(o);
    step(o);
    checks++;
    if (o.vld !== 1'b1 || o.grant !== '0 || o.data !== mk_data(0, 7, 0)) begin
      errors++;
      $display("FAIL rst_prio got vld=%b grant=%0d data=%h exp 1 0 %h",
               o.vld, o.grant, o.data, mk_data(0, 7, 0));
    end
  endtask

  task automatic test_random();
    obs_t o;
    int owner = -1;
    int mlast = NI - 1;
    bit mfirst = 1'b0;
    int pk[NI] = '{default: 0};
    int p;
    logic eb, ev, ee, xf;
    logic [NI-1:0] er;
    logic [DW-1:0] ed;
    logic [EW-1:0] em;
    logic es, eeop;
    bit ok;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          push_pkt(i, pk[i], $urandom_range(1, 4), $urandom_range(0, 7) != 0);
          pk[i]++;
        end
        vld_en[i] = $urandom_range(0, 4) != 0;
      end
      out_rdy = $urandom_range(0, 3) != 0;
      step(o);
      eb = owner >= 0;
      ev = eb && o.ivld[owner];
      er = eb && out_rdy ? NI'(1) << owner : '0;
      es = eb ? o.isop[owner] : 1'b0;
      eeop = eb ? o.ieop[owner] : 1'b0;
      ed = eb ? o.idata[owner*DW +: DW] : '0;
      em = eb ? o.iempty[owner*EW +: EW] : '0;
      xf = ev && out_rdy;
      ee = xf && mfirst && !es;
      ok = (o.busy === eb) && (o.vld === ev) && (o.in_rdy === er) && (o.err === ee) &&
           (!eb || o.grant === GW'(owner)) &&
           (!ev || {o.sop, o.eop, o.empty, o.data} === {es, eeop, em, ed});
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_cycle %0d got busy=%b vld=%b in_rdy=%b err=%b grant=%0d sop=%b eop=%b data=%h exp busy=%b vld=%b in_rdy=%b err=%b grant=%0d sop=%b eop=%b data=%h",
                 c, o.busy, o.vld, o.in_rdy, o.err, o.grant, o.sop, o.eop, o.data,
                 eb, ev, er, ee, owner, es, eeop, ed);
      end
      if (owner < 0) begin
        p = rr_next(o.ivld, mlast, -1);
        if (p >= 0) begin
          owner = p; mlast = p; mfirst = 1'b1;
        end
      end else if (xf) begin
        mfirst = 1'b0;
        if (eeop) begin
          p = rr_next(o.ivld, mlast, owner);
          if (p >= 0) begin
            owner = p; mlast = p; mfirst = 1'b1;
          end else begin
            owner = -1;
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    rst = 1'b1;
    out_rdy = 1'b1;
    in_vld = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_three_way();
    test_back_to_back();
    test_backpressure();
    test_err_sop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
